// File: rtl/mem_arb.sv
// Purpose : single-port burst-bus arbiter shared by I-cache refills and D-cache
//           refills/writebacks, plus the atomic-operation bus lock (amo_req/amo_ack).
// Latency : request seen in IDLE -> bus_req next cycle; ack one cycle after the
//           last beat; at least one idle cycle between transactions.
// Backpressure: bus_req held until bus_gnt; read beats follow bus_rvalid and
//           write beats follow bus_wready (dc_wnext mirrors it), so the bus paces
//           every beat.
//
// Optional feature macro: ARB_RR_EN
//   defined   : round-robin between I-cache and D-cache when both are pending
//   undefined : fixed priority, D-cache over I-cache
//
// Port summary
//   clk, rst_n            clock, synchronous active-low reset
//   ic_req_i/ic_addr_i    I-cache line read request and line address
//   ic_rdata_o/_rvalid_o  read beats routed to the I-cache
//   ic_ack_o              one-cycle completion pulse to the I-cache
//   dc_req_i/dc_we_i      D-cache request; we=1 writeback, we=0 refill
//   dc_addr_i/dc_wdata_i  D-cache line address and current write beat
//   dc_wnext_o            write beat consumed, D-cache advances
//   dc_rdata_o/_rvalid_o  read beats routed to the D-cache
//   dc_ack_o              one-cycle completion pulse to the D-cache
//   amo_req_i/amo_ack_o   atomic bus lock request / lock held
//   bus_*                 external burst bus (req/gnt, we, addr, wdata/wready,
//                         rdata/rvalid)

module mem_arb #(
   parameter int ADDR_W    = 64,
   parameter int DATA_W    = 64,
   parameter int BURST_LEN = 8
) (
   input  logic              clk,
   input  logic              rst_n,

   // I-cache side
   input  logic              ic_req_i,
   input  logic [ADDR_W-1:0] ic_addr_i,
   output logic [DATA_W-1:0] ic_rdata_o,
   output logic              ic_rvalid_o,
   output logic              ic_ack_o,

   // D-cache side
   input  logic              dc_req_i,
   input  logic              dc_we_i,
   input  logic [ADDR_W-1:0] dc_addr_i,
   input  logic [DATA_W-1:0] dc_wdata_i,
   output logic              dc_wnext_o,
   output logic [DATA_W-1:0] dc_rdata_o,
   output logic              dc_rvalid_o,
   output logic              dc_ack_o,

   // Atomic lock
   input  logic              amo_req_i,
   output logic              amo_ack_o,

   // External bus
   output logic              bus_req_o,
   output logic              bus_we_o,
   output logic [ADDR_W-1:0] bus_addr_o,
   input  logic              bus_gnt_i,
   output logic [DATA_W-1:0] bus_wdata_o,
   input  logic              bus_wready_i,
   input  logic [DATA_W-1:0] bus_rdata_i,
   input  logic              bus_rvalid_i
);

   localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_RD   = 3'd2,
      S_WR   = 3'd3,
      S_DONE = 3'd4
   } state_t;

   typedef enum logic {
      OWN_IC = 1'b0,
      OWN_DC = 1'b1
   } owner_t;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t            state_q,   state_d;
   owner_t            owner_q,   owner_d;
   logic [CNT_W-1:0]  cnt_q,     cnt_d;
   logic              lock_q,    lock_d;
   logic [ADDR_W-1:0] addr_q,    addr_d;
   logic              we_q,      we_d;
   // Set when a requester keeps req high through its own DONE cycle; that
   // request is stale and must not win again until req has been seen low.
   logic              ic_hold_q, ic_hold_d;
   logic              dc_hold_q, dc_hold_d;
`ifdef ARB_RR_EN
   owner_t            last_owner_q, last_owner_d;
`endif

   // ------------------------------------------------------------------
   // Requester selection (only consulted in IDLE)
   // ------------------------------------------------------------------
   logic ic_elig;
   logic dc_elig;
   logic pick_dc;

   // The I-cache is masked while the lock is held and also in the very
   // cycle amo_req arrives, so a simultaneous amo_req beats ic_req.
   assign ic_elig = ic_req_i & ~ic_hold_q & ~lock_q & ~amo_req_i;
   assign dc_elig = dc_req_i & ~dc_hold_q;

`ifdef ARB_RR_EN
   always_comb begin
      pick_dc = dc_elig;
      if (ic_elig && dc_elig) begin
         pick_dc = (last_owner_q == OWN_IC);
      end
   end
`else
   assign pick_dc = dc_elig;
`endif

   // ------------------------------------------------------------------
   // Next-state and outputs
   // ------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      we_d        = we_q;
      lock_d      = lock_q;
`ifdef ARB_RR_EN
      last_owner_d = last_owner_q;
`endif

      bus_req_o   = 1'b0;
      bus_wdata_o = '0;
      ic_rvalid_o = 1'b0;
      ic_ack_o    = 1'b0;
      dc_rvalid_o = 1'b0;
      dc_wnext_o  = 1'b0;
      dc_ack_o    = 1'b0;

      // Lock only takes effect between transactions; dropping amo_req
      // releases it on the next edge whatever the state, and any
      // in-flight D-cache burst simply runs to completion.
      if (!amo_req_i) begin
         lock_d = 1'b0;
      end else if (state_q == S_IDLE) begin
         lock_d = 1'b1;
      end

      // Stale-request tracking
      ic_hold_d = ic_hold_q & ic_req_i;
      dc_hold_d = dc_hold_q & dc_req_i;
      if (state_q == S_DONE) begin
         if (owner_q == OWN_IC) ic_hold_d = ic_req_i;
         else                   dc_hold_d = dc_req_i;
      end

      case (state_q)
         S_IDLE: begin
            if (ic_elig || dc_elig) begin
               state_d = S_REQ;
               if (pick_dc) begin
                  owner_d = OWN_DC;
                  addr_d  = dc_addr_i;
                  we_d    = dc_we_i;
               end else begin
                  owner_d = OWN_IC;
                  addr_d  = ic_addr_i;
                  we_d    = 1'b0;
               end
            end
         end

         S_REQ: begin
            bus_req_o = 1'b1;
            if (bus_gnt_i) begin
               state_d = we_q ? S_WR : S_RD;
            end
         end

         S_RD: begin
            if (bus_rvalid_i) begin
               ic_rvalid_o = (owner_q == OWN_IC);
               dc_rvalid_o = (owner_q == OWN_DC);
               cnt_d       = cnt_q + CNT_ONE;
               if (cnt_q == LAST_BEAT) begin
                  state_d = S_DONE;
               end
            end
         end

         S_WR: begin
            // Only the D-cache ever writes, so its beat goes straight out.
            bus_wdata_o = dc_wdata_i;
            dc_wnext_o  = bus_wready_i;
            if (bus_wready_i) begin
               cnt_d = cnt_q + CNT_ONE;
               if (cnt_q == LAST_BEAT) begin
                  state_d = S_DONE;
               end
            end
         end

         S_DONE: begin
            ic_ack_o = (owner_q == OWN_IC);
            dc_ack_o = (owner_q == OWN_DC);
            cnt_d    = '0;
`ifdef ARB_RR_EN
            last_owner_d = owner_q;
`endif
            state_d  = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         owner_q   <= OWN_IC;
         cnt_q     <= '0;
         lock_q    <= 1'b0;
         addr_q    <= '0;
         we_q      <= 1'b0;
         ic_hold_q <= 1'b0;
         dc_hold_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         cnt_q     <= cnt_d;
         lock_q    <= lock_d;
         addr_q    <= addr_d;
         we_q      <= we_d;
         ic_hold_q <= ic_hold_d;
         dc_hold_q <= dc_hold_d;
      end
   end

`ifdef ARB_RR_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_owner_q <= OWN_IC;
      end else begin
         last_owner_q <= last_owner_d;
      end
   end
`endif

   // ------------------------------------------------------------------
   // Registered and passthrough outputs
   // ------------------------------------------------------------------
   assign bus_addr_o = addr_q;
   assign bus_we_o   = we_q;
   assign amo_ack_o  = lock_q;
   assign ic_rdata_o = bus_rdata_i;
   assign dc_rdata_o = bus_rdata_i;

endmodule

// File: tb/tb_mem_arb.sv
// Purpose : self-checking bench for mem_arb; bench plays both caches and the bus.
// Latency : expected beats are queued when driven and compared when routed out.
// Backpressure: bus grant delay and write-ready gaps are driven by the bench.

module tb_mem_arb;

   localparam int AW   = 64;
   localparam int DW   = 64;
   localparam int BL   = 8;
   localparam int NONE = 99;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          ic_req, dc_req, dc_we, amo_req;
   logic [AW-1:0] ic_addr, dc_addr;
   logic [DW-1:0] dc_wdata, bus_rdata;
   logic          bus_gnt, bus_wready, bus_rvalid;
   logic [DW-1:0] ic_rdata, dc_rdata, bus_wdata;
   logic [AW-1:0] bus_addr;
   logic          ic_rvalid, ic_ack, dc_wnext, dc_rvalid, dc_ack;
   logic          amo_ack, bus_req, bus_we;

   always #5 clk = ~clk;

   mem_arb #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ic_req_i     (ic_req),
      .ic_addr_i    (ic_addr),
      .ic_rdata_o   (ic_rdata),
      .ic_rvalid_o  (ic_rvalid),
      .ic_ack_o     (ic_ack),
      .dc_req_i     (dc_req),
      .dc_we_i      (dc_we),
      .dc_addr_i    (dc_addr),
      .dc_wdata_i   (dc_wdata),
      .dc_wnext_o   (dc_wnext),
      .dc_rdata_o   (dc_rdata),
      .dc_rvalid_o  (dc_rvalid),
      .dc_ack_o     (dc_ack),
      .amo_req_i    (amo_req),
      .amo_ack_o    (amo_ack),
      .bus_req_o    (bus_req),
      .bus_we_o     (bus_we),
      .bus_addr_o   (bus_addr),
      .bus_gnt_i    (bus_gnt),
      .bus_wdata_o  (bus_wdata),
      .bus_wready_i (bus_wready),
      .bus_rdata_i  (bus_rdata),
      .bus_rvalid_i (bus_rvalid)
   );

   int n_chk  = 0;
   int n_pass = 0;
   int ic_ack_cnt  = 0;
   int dc_ack_cnt  = 0;
   int exp_ic_acks = 0;
   int exp_dc_acks = 0;

   logic [63:0] exp_ic[$];
   logic [63:0] exp_dc[$];
   logic [63:0] exp_wr[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   // Scoreboard side: every routed beat must match the oldest queued one.
   always @(negedge clk) begin
      if (rst_n) begin
         if (ic_rvalid) begin
            if (exp_ic.size() == 0) check("ic_rvalid_unexpected", 1, 0);
            else check("ic_rdata", ic_rdata, exp_ic.pop_front());
         end
         if (dc_rvalid) begin
            if (exp_dc.size() == 0) check("dc_rvalid_unexpected", 1, 0);
            else check("dc_rdata", dc_rdata, exp_dc.pop_front());
         end
         if (dc_wnext) begin
            if (exp_wr.size() == 0) check("dc_wnext_unexpected", 1, 0);
            else check("bus_wdata", bus_wdata, exp_wr.pop_front());
         end
         if (ic_ack) ic_ack_cnt++;
         if (dc_ack) dc_ack_cnt++;
      end
   end

   task automatic check_reset_outputs();
      check("rst_bus_req",   bus_req,   0);
      check("rst_bus_we",    bus_we,    0);
      check("rst_bus_addr",  bus_addr,  0);
      check("rst_bus_wdata", bus_wdata, 0);
      check("rst_ic_rvalid", ic_rvalid, 0);
      check("rst_ic_ack",    ic_ack,    0);
      check("rst_dc_wnext",  dc_wnext,  0);
      check("rst_dc_rvalid", dc_rvalid, 0);
      check("rst_dc_ack",    dc_ack,    0);
      check("rst_amo_ack",   amo_ack,   0);
      check("rst_ic_rdata",  ic_rdata,  bus_rdata);
      check("rst_dc_rdata",  dc_rdata,  bus_rdata);
   endtask

   // Serve one line transaction as the bus, acting as the owning cache too.
   task automatic bus_xact(input logic we, input logic [63:0] addr, input logic own_dc,
                           input int gnt_dly, input logic drop_req,
                           input int amo_at, input int abort_at);
      int t;
      logic [63:0] d;
      t = 0;
      while (bus_req !== 1'b1 && t < 60) begin
         @(negedge clk);
         t++;
      end
      if (bus_req !== 1'b1) begin
         check("bus_req_timeout", 0, 1);
         return;
      end
      check("bus_addr", bus_addr, addr);
      check("bus_we", bus_we, we);
      for (int k = 0; k < gnt_dly; k++) begin
         @(posedge clk); #1;
         check("bus_req_hold", bus_req, 1);
      end
      #1 bus_gnt = 1'b1;
      @(posedge clk); #1;
      bus_gnt = 1'b0;
      check("bus_req_drop", bus_req, 0);
      for (int i = 0; i < BL; i++) begin
         if (i == amo_at) amo_req = 1'b1;
         if (i == abort_at) begin
            rst_n  = 1'b0;
            ic_req = 1'b0;
            dc_req = 1'b0;
            @(posedge clk); #1;
            check_reset_outputs();
            rst_n = 1'b1;
            return;
         end
         d = {addr[31:0], 32'(i)};
         if (we) begin
            dc_wdata   = d;
            bus_wready = 1'b1;
            exp_wr.push_back(d);
         end else begin
            bus_rdata  = d;
            bus_rvalid = 1'b1;
            if (own_dc) exp_dc.push_back(d);
            else        exp_ic.push_back(d);
         end
         @(posedge clk); #1;
         bus_rvalid = 1'b0;
         bus_wready = 1'b0;
         if (we && i < BL - 1) begin
            @(posedge clk); #1;
         end
      end
      check("owner_ack", own_dc ? dc_ack : ic_ack, 1);
      check("other_ack", own_dc ? ic_ack : dc_ack, 0);
      if (own_dc) exp_dc_acks++;
      else        exp_ic_acks++;
      if (drop_req) begin
         if (own_dc) dc_req = 1'b0;
         else        ic_req = 1'b0;
      end
      @(posedge clk); #1;
      check("ack_one_cycle", ic_ack | dc_ack, 0);
      check("beats_left", exp_ic.size() + exp_dc.size() + exp_wr.size(), 0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; ic_req = 0; dc_req = 0; dc_we = 0; amo_req = 0;
      ic_addr = '0; dc_addr = '0; dc_wdata = 64'h1234_5678;
      bus_rdata = 64'hDEAD_BEEF_0123_4567;
      bus_gnt = 0; bus_wready = 0; bus_rvalid = 0;

      // Reset state
      repeat (3) @(posedge clk);
      #1 check_reset_outputs();
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Stray beats in IDLE are ignored
      bus_rvalid = 1'b1; bus_wready = 1'b1;
      @(negedge clk);
      check("idle_rvalid_ic", ic_rvalid, 0);
      check("idle_rvalid_dc", dc_rvalid, 0);
      check("idle_wnext",     dc_wnext,  0);
      @(posedge clk); #1;
      bus_rvalid = 1'b0; bus_wready = 1'b0;

      // D-cache writeback, wready on alternate cycles, req held across DONE
      dc_we = 1'b1; dc_addr = 64'h4000; dc_req = 1'b1;
      bus_xact(1'b1, 64'h4000, 1'b1, 1, 1'b0, NONE, NONE);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         check("held_req_no_regrant", bus_req, 0);
      end
      dc_req = 1'b0;
      @(posedge clk); #1;
      dc_we = 1'b0; dc_addr = 64'h4040; dc_req = 1'b1;
      bus_xact(1'b0, 64'h4040, 1'b1, 0, 1'b1, NONE, NONE);

      // I-cache refill, grant after 2 cycles
      ic_addr = 64'h8000_0040; ic_req = 1'b1;
      bus_xact(1'b0, 64'h8000_0040, 1'b0, 2, 1'b1, NONE, NONE);

      // Both requesters at once, last owner is the I-cache
      ic_addr = 64'h8000_0080; ic_req = 1'b1;
      dc_we = 1'b0; dc_addr = 64'h1000; dc_req = 1'b1;
      bus_xact(1'b0, 64'h1000, 1'b1, 1, 1'b1, NONE, NONE);
      dc_addr = 64'h2000; dc_req = 1'b1;
`ifdef ARB_RR_EN
      bus_xact(1'b0, 64'h8000_0080, 1'b0, 0, 1'b1, NONE, NONE);
      bus_xact(1'b0, 64'h2000,      1'b1, 0, 1'b1, NONE, NONE);
`else
      bus_xact(1'b0, 64'h2000,      1'b1, 0, 1'b1, NONE, NONE);
      bus_xact(1'b0, 64'h8000_0080, 1'b0, 0, 1'b1, NONE, NONE);
`endif

      // Atomic lock raised mid I-cache burst
      ic_addr = 64'h8000_00C0; ic_req = 1'b1;
      bus_xact(1'b0, 64'h8000_00C0, 1'b0, 1, 1'b1, 3, NONE);
      check("amo_ack_not_during_burst", amo_ack, 0);
      @(posedge clk); #1;
      check("amo_ack_set", amo_ack, 1);
      ic_addr = 64'h8000_0100; ic_req = 1'b1;
      dc_addr = 64'h3000; dc_req = 1'b1;
      bus_xact(1'b0, 64'h3000, 1'b1, 0, 1'b1, NONE, NONE);
      check("amo_ack_held", amo_ack, 1);
      dc_addr = 64'h3040; dc_req = 1'b1;
      bus_xact(1'b0, 64'h3040, 1'b1, 1, 1'b1, NONE, NONE);
      amo_req = 1'b0;
      check("ic_still_locked_out", bus_req, 0);
      @(posedge clk); #1;
      check("amo_ack_clear", amo_ack, 0);
      check("ic_not_yet_granted", bus_req, 0);
      bus_xact(1'b0, 64'h8000_0100, 1'b0, 0, 1'b1, NONE, NONE);

      // Reset at beat 4 of a read, then a clean refill
      ic_addr = 64'h8000_0140; ic_req = 1'b1;
      bus_xact(1'b0, 64'h8000_0140, 1'b0, 0, 1'b1, NONE, 4);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         check("no_ack_after_reset", ic_ack, 0);
         check("no_req_after_reset", bus_req, 0);
      end
      ic_addr = 64'h8000_0180; ic_req = 1'b1;
      bus_xact(1'b0, 64'h8000_0180, 1'b0, 1, 1'b1, NONE, NONE);

      repeat (2) @(posedge clk);
      #1;
      check("ic_ack_total", ic_ack_cnt, exp_ic_acks);
      check("dc_ack_total", dc_ack_cnt, exp_dc_acks);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mem_arb.md
Name: mem_arb

Overview:
Single-port memory-bus arbiter for the core. It shares one burst bus between I-cache line refills and D-cache line refills/writebacks. It also provides the atomic-operation bus lock that answers the core's amo_req with amo_ack, which the control unit uses to release the stall.
- Sits between both L1 caches and the external bus interface.
- Each granted transaction is one cache-line burst of BURST_LEN beats.

Parameters:
ADDR_W, 64, physical address width (line-aligned addresses).
DATA_W, 64, beat width.
BURST_LEN, 8, beats per line transfer; power of two, >= 2.

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
ic_req  input  1  I-cache line read request; held until ic_ack
ic_addr  input  ADDR_W  I-cache line address; stable while ic_req
ic_rdata  output  DATA_W  read beat data (bus_rdata passthrough)
ic_rvalid  output  1  read beat valid to I-cache
ic_ack  output  1  one-cycle pulse: I-cache transaction complete
dc_req  input  1  D-cache request; held until dc_ack
dc_we  input  1  1 = line writeback, 0 = line refill; stable while dc_req
dc_addr  input  ADDR_W  D-cache line address
dc_wdata  input  DATA_W  current write beat
dc_wnext  output  1  write beat consumed; D-cache advances to next beat
dc_rdata  output  DATA_W  read beat data
dc_rvalid  output  1  read beat valid to D-cache
dc_ack  output  1  one-cycle pulse: D-cache transaction complete
amo_req  input  1  core requests atomic bus lock
amo_ack  output  1  lock held; only D-cache may own the bus
bus_req  output  1  transaction request to bus
bus_we  output  1  write transaction
bus_addr  output  ADDR_W  line address
bus_gnt  input  1  bus accepts request
bus_wdata  output  DATA_W  write beat
bus_wready  input  1  bus consumed write beat
bus_rdata  input  DATA_W  read beat
bus_rvalid  input  1  read beat valid

Behaviour:
- Reset: state IDLE. Beat counter = 0, lock = 0, last-owner = ICACHE.
  - All outputs 0, except the passthrough data buses ic_rdata/dc_rdata = bus_rdata.
- States and transitions:
  - IDLE -> REQ: on a selected requester. bus_addr/bus_we are registered and bus_req = 1 from the next cycle.
  - REQ: bus_req held high until bus_gnt is sampled high. Then -> RD if bus_we = 0, else -> WR. bus_req drops the same edge.
  - RD: each bus_rvalid beat is routed to the owner's *_rvalid in the same cycle (combinational) and increments the counter. The beat where counter == BURST_LEN-1 -> DONE.
  - WR: bus_wdata = dc_wdata (combinational). dc_wnext = bus_wready. The counter increments per bus_wready. The final beat -> DONE.
  - DONE: owner's *_ack = 1 for exactly one cycle. Counter cleared, last-owner updated. -> IDLE.
- Ack timing: ack occurs the cycle after the last beat. Requester drops req on the ack cycle. A new grant is evaluated in IDLE the following cycle, giving a minimum 1 idle cycle between transactions.
- Beat routing: rvalid is never asserted to the non-owner. bus_rvalid/bus_wready outside RD/WR are ignored.
- Selection in IDLE: see the optional feature. A request held high across DONE is not re-granted until the owner re-asserts after ack.
- Lock (amo_ack):
  - lock sets in IDLE when amo_req = 1 and state is IDLE; any in-flight I-cache transaction finishes first.
  - While lock = 1, ic_req is masked and only the D-cache is granted, back-to-back.
  - amo_ack = lock (registered).
  - lock clears the cycle after amo_req is sampled 0. An in-flight D-cache transaction completes normally.
- Simultaneous: amo_req and ic_req both arriving in IDLE -> lock wins and the I-cache waits.
- Reset mid-transaction: immediately IDLE with all state cleared. The beat count is abandoned and no ack is issued.

Optional Feature:
ARB_RR_EN
- Defined: round-robin. When ic_req and dc_req are both pending in IDLE, the grant goes to the requester that is not last-owner.
- Undefined: fixed priority, D-cache over I-cache; last-owner is unused.
- Lock masking applies in both modes.

Test Plan:
- ic_req only, addr 0x8000_0040, bus_gnt after 2 cycles, 8 rvalid beats 0..7 -> 8 ic_rvalid pulses with data 0..7, ic_ack 1 cycle after beat 7, dc_rvalid stays 0.
- dc_req with dc_we = 1, bus_wready on alternate cycles -> bus_we = 1, 8 dc_wnext pulses aligned to wready, dc_ack after the 8th.
- ic_req and dc_req raised the same cycle, last-owner = ICACHE:
  - ARB_RR_EN: dc first, then ic.
  - Without it: dc first, and dc is re-granted if it re-requests before ic.
- amo_req raised during an I-cache burst -> burst completes, amo_ack = 1 in IDLE, a later ic_req is held off across two D-cache transactions, amo_ack = 0 after amo_req falls, then the I-cache is granted.
- rst_n low at beat 4 of a read -> next cycle all outputs 0, state IDLE, no ack. A fresh request completes with exactly 8 beats.
